uart_ctrl: RTL and testbench
============================

# uart_ctrl

Memory-mapped controller between the RISC-V core's peripheral bus and the byte-level UART. It buffers transmit bytes in a TX FIFO and feeds them to the UART one frame at a time with a small sequencing state machine. It captures received bytes into an RX FIFO, reports status and sticky error flags, and raises a level interrupt to the core.

## Interface
- TX_DEPTH, 16, TX FIFO depth in bytes; power of two, ≥2
- RX_DEPTH, 16, RX FIFO depth in bytes; power of two, ≥2
- CLK  in  1  main clock
- RESETB  in  1  asynchronous, active-low reset
- ADDR  in  2  register word select: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
- WR_EN  in  1  one-cycle write strobe
- WR_DATA  in  8  write data
- RD_EN  in  1  one-cycle read strobe
- RD_DATA  out  32  registered read data, zero-extended
- IRQ  out  1  level interrupt
- UART_TX_DATA  out  8  byte presented to the UART
- UART_TX_DATA_EN  out  1  one-cycle frame start to the UART
- UART_TX_BUSY  in  1  UART transmitter busy
- UART_RX_DATA  in  8  received byte
- UART_RX_DATA_EN  in  1  one-cycle received-byte strobe

## Operation
- DATA write: pushes WR_DATA into the TX FIFO. If the FIFO is full, the byte is dropped and the sticky bit tx_ovf is set.
- DATA read: returns the RX FIFO head in bits [7:0] and pops it. If the FIFO is empty, returns 0 with no pop.
- STATUS read bits:
  - [0] rx_avail: RX FIFO not empty
  - [1] tx_full
  - [2] tx_idle: TX FIFO empty and FSM in IDLE
  - [3] rx_ovr
  - [4] tx_ovf
  - other bits read 0
- STATUS read clears rx_ovr and tx_ovf. A set event in the same cycle as the clearing read wins, so the bit stays set.
- CTRL: bit0 rx_ie, bit1 tx_ie; read back in [1:0]. Writes to address 3 are ignored; reads of address 3 return 0.
- IRQ = (rx_ie & rx_avail) | (tx_ie & tx_idle), registered.
- RX path:
  - UART_RX_DATA_EN pushes UART_RX_DATA into the RX FIFO.
  - If the FIFO is full with no pop in the same cycle, the byte is dropped and rx_ovr is set.
  - A full FIFO with a simultaneous pop and push accepts the push; rx_ovr is not set.
- TX path: the same rule applies. A write to a full FIFO in the same cycle as the FSM pop is accepted.
- TX FSM states and transitions:
  - IDLE: when the TX FIFO is not empty, pop the head into the UART_TX_DATA register and go to LAUNCH.
  - LAUNCH: UART_TX_DATA_EN=1 for this cycle only; go to WAIT_BUSY.
  - WAIT_BUSY: when UART_TX_BUSY=1, go to WAIT_DONE.
  - WAIT_DONE: when UART_TX_BUSY=0, go to IDLE.
- UART_TX_DATA holds its value from the pop until the next pop.
- FIFO pointers are log2(DEPTH)+1 bits, wrap modulo 2·DEPTH. Full = MSBs differ and the rest are equal; empty = equal.
- Reset values:
  - RD_DATA=0, IRQ=0
  - UART_TX_DATA=0, UART_TX_DATA_EN=0
  - FSM=IDLE, both FIFOs empty, CTRL=0, sticky bits=0
- Reset asserted mid-frame immediately returns everything to the reset values. Queued bytes are discarded; no partial state survives.

## Timing
- RD_DATA is valid in the cycle after the RD_EN edge and holds until the next read. A pop caused by a DATA read is visible in STATUS on the following read.
- Write-to-launch: with the FSM in IDLE and the TX FIFO empty, WR_EN to DATA sampled at edge k gives UART_TX_DATA_EN high for exactly the cycle following edge k+2. UART_TX_DATA is already valid in that cycle.
- UART_TX_BUSY rises one cycle after UART_TX_DATA_EN; WAIT_BUSY tolerates any delay.
- Back-to-back frames: the next UART_TX_DATA_EN is asserted 3 cycles after UART_TX_BUSY falls (WAIT_DONE→IDLE→LAUNCH). UART_TX_DATA_EN is never asserted while UART_TX_BUSY=1.
- RX push lands at the edge where UART_RX_DATA_EN=1; rx_avail is visible on a STATUS read issued the next cycle.
- IRQ lags its source by one cycle.
- Simultaneous RD_EN and WR_EN: both are performed.

## Test plan
- Single TX byte: write 0x55 to DATA → one UART_TX_DATA_EN pulse with UART_TX_DATA=0x55 two cycles later. STATUS tx_idle=0 during the frame and 1 once UART_TX_BUSY falls.
- TX burst and overflow: write 0x01..0x12 (18 bytes) back-to-back with TX_DEPTH=16 → STATUS reports tx_ovf=1 on the first read and 0 on the second read.
  - The UART must see the accepted bytes in order, starting 0x01, 0x02, ….
  - Exactly 1 byte is dropped: the FSM pops 0x01 before the write of 0x12, so 17 bytes are accepted.
- RX fill/overrun: 17 UART_RX_DATA_EN pulses carrying 0xA0..0xB0 with no reads → 16 DATA reads return 0xA0..0xAF, then 0. rx_ovr=1, then cleared after the STATUS read.
- Full boundary: with the RX FIFO full, issue a DATA read and UART_RX_DATA_EN=0xC3 in the same cycle → rx_ovr stays 0; 0xC3 is read last.
- IRQ: CTRL=0x1, push one RX byte → IRQ=1. Reading DATA drops IRQ the cycle after the pop. CTRL=0x2 with TX idle → IRQ=1.
- Reset mid-frame: queue 4 bytes, assert RESETB low during WAIT_DONE → all outputs at reset values. No further UART_TX_DATA_EN after RESETB is released.

Source files
------------

// File: rtl/uart_ctrl.sv
// rtl/uart_ctrl.sv - Memory-mapped UART controller: TX/RX byte FIFOs, status/sticky flags, TX frame sequencer, level IRQ

module uart_ctrl_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_mem [DEPTH];
    logic        w_pop_ok;
    logic        w_push_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}});
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_pop_ok  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end
endmodule

module uart_ctrl #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RESETB,
    input  logic [1:0]  ADDR,
    input  logic        WR_EN,
    input  logic [7:0]  WR_DATA,
    input  logic        RD_EN,
    output logic [31:0] RD_DATA,
    output logic        IRQ,
    output logic [7:0]  UART_TX_DATA,
    output logic        UART_TX_DATA_EN,
    input  logic        UART_TX_BUSY,
    input  logic [7:0]  UART_RX_DATA,
    input  logic        UART_RX_DATA_EN
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t     r_state;
    logic [1:0] r_ctrl;
    logic       r_rx_ovr;
    logic       r_tx_ovf;

    logic       w_data_wr;
    logic       w_data_rd;
    logic       w_stat_rd;
    logic       w_ctrl_wr;
    logic       w_tx_empty;
    logic       w_tx_full;
    logic       w_tx_pop;
    logic [7:0] w_tx_head;
    logic       w_rx_empty;
    logic       w_rx_full;
    logic       w_rx_pop;
    logic [7:0] w_rx_head;
    logic       w_tx_idle;
    logic       w_rx_ovr_set;
    logic       w_tx_ovf_set;

    assign w_data_wr = WR_EN & (ADDR == 2'd0);
    assign w_ctrl_wr = WR_EN & (ADDR == 2'd2);
    assign w_data_rd = RD_EN & (ADDR == 2'd0);
    assign w_stat_rd = RD_EN & (ADDR == 2'd1);

    assign w_tx_pop  = (r_state == S_IDLE) & ~w_tx_empty;
    assign w_rx_pop  = w_data_rd & ~w_rx_empty;
    assign w_tx_idle = w_tx_empty & (r_state == S_IDLE);

    assign w_tx_ovf_set = w_data_wr & w_tx_full & ~w_tx_pop;
    assign w_rx_ovr_set = UART_RX_DATA_EN & w_rx_full & ~w_rx_pop;

    uart_ctrl_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk         (CLK),
        .rst_n       (RESETB),
        .i_push      (w_data_wr),
        .i_push_data (WR_DATA),
        .i_pop       (w_tx_pop),
        .o_head      (w_tx_head),
        .o_full      (w_tx_full),
        .o_empty     (w_tx_empty)
    );

    uart_ctrl_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk         (CLK),
        .rst_n       (RESETB),
        .i_push      (UART_RX_DATA_EN),
        .i_push_data (UART_RX_DATA),
        .i_pop       (w_rx_pop),
        .o_head      (w_rx_head),
        .o_full      (w_rx_full),
        .o_empty     (w_rx_empty)
    );

    // Frame sequencer; the launch pulse is registered so it lands one cycle after LAUNCH is entered
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_state         <= S_IDLE;
            UART_TX_DATA    <= 8'd0;
            UART_TX_DATA_EN <= 1'b0;
        end else begin
            UART_TX_DATA_EN <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_tx_empty) begin
                        UART_TX_DATA <= w_tx_head;
                        r_state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    UART_TX_DATA_EN <= 1'b1;
                    r_state         <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (UART_TX_BUSY) r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (!UART_TX_BUSY) r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_ctrl   <= 2'd0;
            r_rx_ovr <= 1'b0;
            r_tx_ovf <= 1'b0;
            RD_DATA  <= 32'd0;
            IRQ      <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_ctrl <= WR_DATA[1:0];
            // Set beats the clearing STATUS read
            r_rx_ovr <= w_rx_ovr_set | (r_rx_ovr & ~w_stat_rd);
            r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~w_stat_rd);
            if (RD_EN) begin
                case (ADDR)
                    2'd0:    RD_DATA <= {24'd0, (w_rx_empty ? 8'd0 : w_rx_head)};
                    2'd1:    RD_DATA <= {27'd0, r_tx_ovf, r_rx_ovr, w_tx_idle, w_tx_full, ~w_rx_empty};
                    2'd2:    RD_DATA <= {30'd0, r_ctrl};
                    default: RD_DATA <= 32'd0;
                endcase
            end
            IRQ <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_idle);
        end
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// tb/tb_uart_ctrl.sv - Self-checking bench for uart_ctrl with a UART busy model and queue-based reference

module tb_uart_ctrl;
    localparam int TX_DEPTH = 16;
    localparam int RX_DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RESETB;
    logic [1:0]  ADDR;
    logic        WR_EN;
    logic [7:0]  WR_DATA;
    logic        RD_EN;
    logic [31:0] RD_DATA;
    logic        IRQ;
    logic [7:0]  UART_TX_DATA;
    logic        UART_TX_DATA_EN;
    logic        UART_TX_BUSY;
    logic [7:0]  UART_RX_DATA;
    logic        UART_RX_DATA_EN;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] mon_data[$];
    int         mon_cyc[$];
    logic       mon_busy[$];
    int         fall_q[$];

    uart_ctrl #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .CLK             (CLK),
        .RESETB          (RESETB),
        .ADDR            (ADDR),
        .WR_EN           (WR_EN),
        .WR_DATA         (WR_DATA),
        .RD_EN           (RD_EN),
        .RD_DATA         (RD_DATA),
        .IRQ             (IRQ),
        .UART_TX_DATA    (UART_TX_DATA),
        .UART_TX_DATA_EN (UART_TX_DATA_EN),
        .UART_TX_BUSY    (UART_TX_BUSY),
        .UART_RX_DATA    (UART_RX_DATA),
        .UART_RX_DATA_EN (UART_RX_DATA_EN)
    );

    initial forever #5 CLK = ~CLK;
    initial forever begin @(posedge CLK); cyc = cyc + 1; end

    // UART transmitter model: busy after a short random delay, for a random frame length
    initial begin
        UART_TX_BUSY = 1'b0;
        forever begin
            @(negedge CLK);
            if (UART_TX_DATA_EN === 1'b1) begin
                repeat ($urandom_range(1, 3)) @(negedge CLK);
                UART_TX_BUSY = 1'b1;
                repeat ($urandom_range(15, 22)) @(negedge CLK);
                UART_TX_BUSY = 1'b0;
                fall_q.push_back(cyc);
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        if (UART_TX_DATA_EN === 1'b1) begin
            mon_data.push_back(UART_TX_DATA);
            mon_cyc.push_back(cyc);
            mon_busy.push_back(UART_TX_BUSY);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        mon_data.delete(); mon_cyc.delete(); mon_busy.delete(); fall_q.delete();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        ADDR = a; WR_DATA = d; WR_EN = 1'b1;
        @(negedge CLK);
        WR_EN = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        ADDR = a; RD_EN = 1'b1;
        @(negedge CLK);
        RD_EN = 1'b0;
        d = RD_DATA;
    endtask

    task automatic rx_push(input logic [7:0] b);
        UART_RX_DATA = b; UART_RX_DATA_EN = 1'b1;
        @(negedge CLK);
        UART_RX_DATA_EN = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while ((mon_data.size() < n || fall_q.size() < n) && t < 4000) begin
            @(negedge CLK); t++;
        end
        n_tests++;
        if (mon_data.size() < n || fall_q.size() < n) begin
            n_fail++;
            $display("FAIL frame_wait: got %0d frames, required %0d", mon_data.size(), n);
        end
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        RESETB = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0; ADDR = 2'd0; WR_DATA = 8'd0;
        UART_RX_DATA = 8'd0; UART_RX_DATA_EN = 1'b0;
        repeat (3) @(negedge CLK);
        n_tests++; if (RD_DATA !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h, required 0", RD_DATA); end
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b, required 0", IRQ); end
        n_tests++; if (UART_TX_DATA !== 8'd0) begin n_fail++; $display("FAIL reset_tx_data: got %h, required 0", UART_TX_DATA); end
        n_tests++; if (UART_TX_DATA_EN !== 1'b0) begin n_fail++; $display("FAIL reset_tx_en: got %b, required 0", UART_TX_DATA_EN); end
        RESETB = 1'b1;
        @(negedge CLK);
        bus_read(2'd1, d);
        n_tests++; if (d !== 32'h4) begin n_fail++; $display("FAIL reset_status: got %h, required 00000004", d); end
        bus_write(2'd3, 8'hFF);
        bus_read(2'd2, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h, required 0", d); end
        bus_read(2'd3, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL addr3_read: got %h, required 0", d); end
        bus_read(2'd0, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL empty_data_read: got %h, required 0", d); end
    endtask

    task automatic test_single_tx();
        logic [31:0] d;
        int wcyc, t;
        clear_mon();
        wcyc = cyc;
        bus_write(2'd0, 8'h55);
        t = 0;
        while (UART_TX_BUSY !== 1'b1 && t < 100) begin @(negedge CLK); t++; end
        bus_read(2'd1, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL single_status_busy: got %h, required 0", d); end
        wait_frames(1);
        n_tests++; if (mon_data.size() != 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d, required 1", mon_data.size()); end
        if (mon_data.size() >= 1) begin
            n_tests++; if (mon_data[0] !== 8'h55) begin n_fail++; $display("FAIL single_byte: got %h, required 55", mon_data[0]); end
            n_tests++; if (mon_cyc[0] != wcyc + 3) begin n_fail++; $display("FAIL single_latency: got %0d, required %0d", mon_cyc[0] - wcyc, 3); end
        end
        bus_read(2'd1, d);
        n_tests++; if (d !== 32'h4) begin n_fail++; $display("FAIL single_status_idle: got %h, required 00000004", d); end
    endtask

    task automatic test_tx_burst_ovf();
        logic [31:0] d;
        int wcyc;
        clear_mon();
        wcyc = cyc;
        for (int i = 1; i <= 18; i++) bus_write(2'd0, 8'(i));
        bus_read(2'd1, d);
        n_tests++; if (d !== 32'h12) begin n_fail++; $display("FAIL burst_status1: got %h, required 00000012", d); end
        bus_read(2'd1, d);
        n_tests++; if (d !== 32'h02) begin n_fail++; $display("FAIL burst_status2: got %h, required 00000002", d); end
        wait_frames(17);
        repeat (60) @(negedge CLK);
        n_tests++; if (mon_data.size() != 17) begin n_fail++; $display("FAIL burst_count: got %0d, required 17", mon_data.size()); end
        for (int i = 0; i < mon_data.size() && i < 17; i++) begin
            n_tests++; if (mon_data[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL burst_byte%0d: got %h, required %h", i, mon_data[i], 8'(i + 1)); end
            n_tests++; if (mon_busy[i] !== 1'b0) begin n_fail++; $display("FAIL burst_en_while_busy%0d: got busy=%b, required 0", i, mon_busy[i]); end
            if (i > 0 && i <= fall_q.size()) begin
                n_tests++; if (mon_cyc[i] - fall_q[i-1] != 3) begin n_fail++; $display("FAIL burst_gap%0d: got %0d, required 3", i, mon_cyc[i] - fall_q[i-1]); end
            end
        end
        if (mon_cyc.size() > 0) begin
            n_tests++; if (mon_cyc[0] != wcyc + 3) begin n_fail++; $display("FAIL burst_latency: got %0d, required 3", mon_cyc[0] - wcyc); end
        end
        bus_read(2'd1, d);
        n_tests++; if (d !== 32'h4) begin n_fail++; $display("FAIL burst_status_end: got %h, required 00000004", d); end
    endtask

    task automatic test_random_tx();
        logic [7:0]  exp_q[$];
        logic [7:0]  b;
        logic [31:0] d;
        clear_mon();
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            bus_write(2'd0, b);
            repeat ($urandom_range(0, 20)) @(negedge CLK);
        end
        wait_frames(12);
        n_tests++; if (mon_data.size() != 12) begin n_fail++; $display("FAIL rtx_count: got %0d, required 12", mon_data.size()); end
        for (int i = 0; i < mon_data.size() && i < 12; i++) begin
            n_tests++; if (mon_data[i] !== exp_q[i]) begin n_fail++; $display("FAIL rtx_byte%0d: got %h, required %h", i, mon_data[i], exp_q[i]); end
            if (i > 0 && i <= fall_q.size()) begin
                n_tests++; if (mon_busy[i] !== 1'b0 || mon_cyc[i] - fall_q[i-1] < 3) begin
                    n_fail++; $display("FAIL rtx_spacing%0d: got gap %0d busy %b, required gap>=3 busy 0", i, mon_cyc[i] - fall_q[i-1], mon_busy[i]);
                end
            end
        end
        bus_read(2'd1, d);
        n_tests++; if (d !== 32'h4) begin n_fail++; $display("FAIL rtx_status: got %h, required 00000004", d); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        for (int i = 0; i < 17; i++) rx_push(8'hA0 + 8'(i));
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd0, d);
            n_tests++; if (d !== 32'(8'hA0 + 8'(i))) begin n_fail++; $display("FAIL rxovr_read%0d: got %h, required %h", i, d, 8'hA0 + 8'(i)); end
        end
        bus_read(2'd0, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rxovr_empty_read: got %h, required 0", d); end
        bus_read(2'd1, d);
        n_tests++; if (d !== 32'h0C) begin n_fail++; $display("FAIL rxovr_status1: got %h, required 0000000c", d); end
        bus_read(2'd1, d);
        n_tests++; if (d !== 32'h04) begin n_fail++; $display("FAIL rxovr_status2: got %h, required 00000004", d); end
    endtask

    task automatic test_full_boundary();
        logic [7:0]  q[$];
        logic [7:0]  b;
        logic [31:0] d;
        for (int i = 0; i < RX_DEPTH; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            rx_push(b);
        end
        UART_RX_DATA = 8'hC3; UART_RX_DATA_EN = 1'b1; ADDR = 2'd0; RD_EN = 1'b1;
        @(negedge CLK);
        UART_RX_DATA_EN = 1'b0; RD_EN = 1'b0;
        b = q.pop_front();
        q.push_back(8'hC3);
        n_tests++; if (RD_DATA !== 32'(b)) begin n_fail++; $display("FAIL full_simul_read: got %h, required %h", RD_DATA, b); end
        bus_read(2'd1, d);
        n_tests++; if (d !== 32'h05) begin n_fail++; $display("FAIL full_status: got %h, required 00000005", d); end
        for (int i = 0; i < RX_DEPTH; i++) begin
            bus_read(2'd0, d);
            n_tests++; if (d !== 32'(q[i])) begin n_fail++; $display("FAIL full_drain%0d: got %h, required %h", i, d, q[i]); end
        end
        bus_read(2'd0, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL full_drained: got %h, required 0", d); end
    endtask

    task automatic test_random_rx();
        logic [7:0]  q[$];
        logic [7:0]  b;
        logic [31:0] d;
        logic        p, r, m_ovr;
        logic [7:0]  exp;
        m_ovr = 1'b0;
        for (int c = 0; c < 200; c++) begin
            p = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 2) == 0);
            b = 8'($urandom);
            UART_RX_DATA = b; UART_RX_DATA_EN = p; ADDR = 2'd0; RD_EN = r;
            @(negedge CLK);
            UART_RX_DATA_EN = 1'b0; RD_EN = 1'b0;
            exp = 8'd0;
            if (r && q.size() > 0) exp = q.pop_front();
            if (p) begin
                if (q.size() < RX_DEPTH) q.push_back(b);
                else m_ovr = 1'b1;
            end
            if (r) begin
                n_tests++; if (RD_DATA !== 32'(exp)) begin n_fail++; $display("FAIL rrx_read_c%0d: got %h, required %h", c, RD_DATA, exp); end
            end
        end
        bus_read(2'd1, d);
        n_tests++; if (d !== {27'd0, 1'b0, m_ovr, 1'b1, 1'b0, (q.size() != 0)}) begin
            n_fail++; $display("FAIL rrx_status: got %h, required ovr=%b avail=%b", d, m_ovr, q.size() != 0);
        end
        while (q.size() > 0) begin
            exp = q.pop_front();
            bus_read(2'd0, d);
            n_tests++; if (d !== 32'(exp)) begin n_fail++; $display("FAIL rrx_drain: got %h, required %h", d, exp); end
        end
        bus_read(2'd1, d);
    endtask

    task automatic test_irq();
        logic [31:0] d;
        bus_write(2'd2, 8'h01);
        rx_push(8'h77);
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_lag: got %b, required 0", IRQ); end
        @(negedge CLK);
        n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_rx_set: got %b, required 1", IRQ); end
        bus_read(2'd0, d);
        n_tests++; if (d !== 32'h77) begin n_fail++; $display("FAIL irq_rx_byte: got %h, required 77", d); end
        n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_hold_at_pop: got %b, required 1", IRQ); end
        @(negedge CLK);
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_rx_clear: got %b, required 0", IRQ); end
        bus_write(2'd2, 8'h02);
        @(negedge CLK);
        n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_tx_idle: got %b, required 1", IRQ); end
        bus_read(2'd2, d);
        n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL ctrl_readback: got %h, required 2", d); end
        bus_write(2'd2, 8'h00);
        @(negedge CLK);
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_disabled: got %b, required 0", IRQ); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        int t;
        bus_write(2'd2, 8'h01);
        rx_push(8'h3C);
        bus_read(2'd2, d);
        clear_mon();
        for (int i = 0; i < 4; i++) bus_write(2'd0, 8'hE0 + 8'(i));
        t = 0;
        while (UART_TX_BUSY !== 1'b1 && t < 100) begin @(negedge CLK); t++; end
        repeat (2) @(negedge CLK);
        n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL rst_pre_irq: got %b, required 1", IRQ); end
        RESETB = 1'b0;
        #1;
        n_tests++; if (RD_DATA !== 32'd0) begin n_fail++; $display("FAIL rst_rd_data: got %h, required 0", RD_DATA); end
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b, required 0", IRQ); end
        n_tests++; if (UART_TX_DATA !== 8'd0) begin n_fail++; $display("FAIL rst_tx_data: got %h, required 0", UART_TX_DATA); end
        n_tests++; if (UART_TX_DATA_EN !== 1'b0) begin n_fail++; $display("FAIL rst_tx_en: got %b, required 0", UART_TX_DATA_EN); end
        @(negedge CLK);
        RESETB = 1'b1;
        clear_mon();
        repeat (60) @(negedge CLK);
        n_tests++; if (mon_data.size() != 0) begin n_fail++; $display("FAIL rst_no_launch: got %0d pulses, required 0", mon_data.size()); end
        bus_read(2'd1, d);
        n_tests++; if (d !== 32'h4) begin n_fail++; $display("FAIL rst_status: got %h, required 00000004", d); end
        bus_read(2'd2, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_ctrl: got %h, required 0", d); end
        bus_read(2'd0, d);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_rx_empty: got %h, required 0", d); end
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_tx_burst_ovf();
        test_random_tx();
        test_rx_overrun();
        test_full_boundary();
        test_random_rx();
        test_irq();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
